// File: rtl/cactus_pkg.sv
// cactus_pkg: shared constants for the small-cactus sprite ROM.
//   HEIGHT/LENGTH/DEPTH : sprite geometry (rows, pixels per row, valid words)
//   AW/DW               : address and pixel widths
//   pixel_t             : 12-bit bbbb_gggg_rrrr pixel
//   FG_COLOR/BG_COLOR   : colours of set and clear bitmap pixels
//   ROW_BITS            : bitmap, one byte per row, MSB = leftmost pixel
package cactus_pkg;

  localparam int HEIGHT = 10;
  localparam int LENGTH = 8;
  localparam int DEPTH  = HEIGHT * LENGTH;
  localparam int AW     = 16;
  localparam int DW     = 12;

  typedef logic [DW-1:0] pixel_t;

  localparam pixel_t FG_COLOR = 12'h535;
  localparam pixel_t BG_COLOR = 12'hfff;

  localparam logic [LENGTH-1:0] ROW_BITS [HEIGHT] = '{
    8'h18, 8'h18, 8'h5a, 8'h5a, 8'h5a,
    8'h7e, 8'h3c, 8'h18, 8'h18, 8'h18
  };

endpackage

// File: rtl/cactus_s_ip_if.sv
// cactus_s_ip_if: pixel read bus between the cactus renderer and the ROM.
//   addr : linear pixel address, row*LENGTH + col (driven by master)
//   dout : pixel colour returned by the ROM (driven by slave)
interface cactus_s_ip_if;
  import cactus_pkg::*;

  logic [AW-1:0] addr;
  pixel_t        dout;

  modport master (output addr, input dout);
  modport slave  (input addr, output dout);

endinterface

// File: rtl/cactus_s_lut.sv
// cactus_s_lut: combinational address-to-pixel map for the cactus bitmap.
//   addr : linear pixel address (full AW bits compared, no aliasing)
//   pix  : FG_COLOR for a set bitmap pixel, BG_COLOR for a clear pixel or
//          any address at or beyond DEPTH
module cactus_s_lut
  import cactus_pkg::*;
(
  input  logic [AW-1:0] addr,
  output pixel_t        pix
);

  // Each word is a constant compare against the full address, so the
  // contents follow the package constants and the range check is explicit.
  always_comb begin
    pix = BG_COLOR;
    if (addr < AW'(DEPTH)) begin
      for (int r = 0; r < HEIGHT; r++) begin
        for (int c = 0; c < LENGTH; c++) begin
          if (addr == AW'(r * LENGTH + c) && ROW_BITS[r][LENGTH-1-c])
            pix = FG_COLOR;
        end
      end
    end
  end

endmodule

// File: rtl/cactus_s_ip.sv
// cactus_s_ip: synchronous small-cactus sprite ROM (8x10, 12-bit pixels).
//   clk   : pixel-side clock, all state on the rising edge
//   rst_n : asynchronous active-low reset, forces dout to BG_COLOR at once
//   bus   : slave side of cactus_s_ip_if (addr in, dout out)
// Read latency is 1 clock. Defining CACTUS_S_OUTREG_EN adds a second
// output register (latency 2); both stages reset to BG_COLOR.
module cactus_s_ip
  import cactus_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  cactus_s_ip_if.slave  bus
);

  pixel_t lut_pix;
  pixel_t stage1;

  cactus_s_lut u_lut (
    .addr (bus.addr),
    .pix  (lut_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage1 <= BG_COLOR;
    else        stage1 <= lut_pix;
  end

`ifdef CACTUS_S_OUTREG_EN
  pixel_t stage2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage2 <= BG_COLOR;
    else        stage2 <= stage1;
  end

  assign bus.dout = stage2;
`else
  assign bus.dout = stage1;
`endif

endmodule

// File: tb/tb_cactus_s_ip.sv
// tb_cactus_s_ip: self-checking bench for cactus_s_ip.
// Expected pixels are pushed to a queue as addresses are driven and popped
// once the read latency has elapsed.
module tb_cactus_s_ip;

`ifdef CACTUS_S_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [7:0] BITMAP [10] = '{
    8'h18, 8'h18, 8'h5a, 8'h5a, 8'h5a,
    8'h7e, 8'h3c, 8'h18, 8'h18, 8'h18
  };

  typedef struct {
    logic [15:0] addr;
    logic [11:0] pix;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q [$];

  cactus_s_ip_if bus ();

  cactus_s_ip dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model(input logic [15:0] a);
    int r;
    int c;
    if (a >= 16'd80) return 12'hfff;
    r = int'(a) / 8;
    c = int'(a) % 8;
    return BITMAP[r][7-c] ? 12'h535 : 12'hfff;
  endfunction

  // Pipeline contents right after reset release are all background.
  task automatic restart_queue();
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      e.addr = 16'hxxxx;
      e.pix  = 12'hfff;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    bus.addr = 16'd0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (bus.dout !== 12'hfff) begin
      bad++;
      $display("FAIL reset_async_initial: dout=%h required=%h", bus.dout, 12'hfff);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.dout !== 12'hfff) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: dout=%h required=%h", i, bus.dout, 12'hfff);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    restart_queue();
  endtask

  task automatic test_sweep();
    exp_t e;
    for (int a = 0; a < 80; a++) begin
      @(negedge clk);
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        total++;
        if (bus.dout !== e.pix) begin
          bad++;
          $display("FAIL sweep addr=%0d: dout=%h required=%h", e.addr, bus.dout, e.pix);
        end
      end
      bus.addr = 16'(a);
      e.addr = 16'(a);
      e.pix  = model(16'(a));
      exp_q.push_back(e);
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    logic [15:0] oor [6] = '{16'd80, 16'd81, 16'h8000, 16'hffff, 16'd79, 16'h0050};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        total++;
        if (bus.dout !== e.pix) begin
          bad++;
          $display("FAIL out_of_range addr=%h: dout=%h required=%h", e.addr, bus.dout, e.pix);
        end
      end
      bus.addr = oor[i];
      e.addr = oor[i];
      e.pix  = model(oor[i]);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] seq_a [8] = '{16'd3, 16'd0, 16'd3, 16'd0, 16'd17, 16'd40, 16'd41, 16'd3};
    logic [11:0] seq_p [8] = '{12'h535, 12'hfff, 12'h535, 12'hfff,
                               12'h535, 12'hfff, 12'h535, 12'h535};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        total++;
        if (bus.dout !== e.pix) begin
          bad++;
          $display("FAIL back_to_back addr=%0d: dout=%h required=%h", e.addr, bus.dout, e.pix);
        end
      end
      bus.addr = seq_a[i];
      e.addr = seq_a[i];
      e.pix  = seq_p[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    // Address 3 is foreground, so a forced background is visible.
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        total++;
        if (bus.dout !== e.pix) begin
          bad++;
          $display("FAIL pre_reset addr=%0d: dout=%h required=%h", e.addr, bus.dout, e.pix);
        end
      end
      bus.addr = 16'd3;
      e.addr = 16'd3;
      e.pix  = 12'h535;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.dout !== 12'hfff) begin
      bad++;
      $display("FAIL reset_mid_cycle: dout=%h required=%h", bus.dout, 12'hfff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    restart_queue();
  endtask

  task automatic test_after_reset();
    exp_t e;
    logic [15:0] seq_a [6] = '{16'd3, 16'd17, 16'd41, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        total++;
        if (bus.dout !== e.pix) begin
          bad++;
          $display("FAIL after_reset addr=%h: dout=%h required=%h", e.addr, bus.dout, e.pix);
        end
      end
      bus.addr = seq_a[i];
      e.addr = seq_a[i];
      e.pix  = model(seq_a[i]);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_out_of_range();
    test_back_to_back();
    test_async_reset();
    test_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cactus_s_ip.md
Name: cactus_s_ip

Overview:
- Synchronous sprite ROM holding the 8x10 small-cactus bitmap for the Chrome-Dino VGA game.
- The cactus renderer drives a linear pixel address, computed as row*LENGTH + col. The ROM returns one 12-bit pixel in bbbb_gggg_rrrr format after a fixed read latency.
- It replaces the vendor block-memory core with portable RTL. It sits between the cactus position/compositing logic and the VGA pixel mux.

Parameters:
- HEIGHT, 10, sprite height in rows.
- LENGTH, 8, sprite width in pixels.
- DEPTH, HEIGHT*LENGTH = 80, number of valid ROM words.
- AW, 16, address width.
- DW, 12, pixel width (bbbb_gggg_rrrr).
- FG_COLOR, 12'h535, colour of set bitmap pixels.
- BG_COLOR, 12'hfff, colour of clear pixels and of out-of-range reads (white).

Ports:
- clk  input  1  pixel-side clock (the game's fast clk_ip domain); all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- addr  input  AW  linear pixel address, row*LENGTH + col; row 0 = top, col 0 = left.
- dout  output  DW  pixel colour.

Behaviour:
- Bitmap, one byte per row, rows 0..9, MSB = col 0: 18,18,5A,5A,5A,7E,3C,18,18,18 (hex).
- Word at addr = r*8 + c is FG_COLOR if bit (7-c) of row r is 1, else BG_COLOR.
- Read is registered: dout reflects the addr sampled at the previous rising edge, so latency is 1 clock. There is no enable; a read occurs every cycle.
- Out of range: if addr >= DEPTH (including wrapped "negative" addresses from upstream subtraction), the registered result is BG_COLOR.
  - No aliasing or modulo; the full AW bits are compared.
- Reset: while rst_n = 0, dout = BG_COLOR immediately, independent of clk.
  - On release, the first rising edge loads the ROM word for the current addr.
- Reset asserted mid-stream forces BG_COLOR at once. Any in-flight read is discarded.
- An address change every cycle is supported with no bubbles or hazards. The ROM is read-only, so there is no write port.
- Contents are fixed at elaboration from the parameters and bitmap constants. Changing FG_COLOR/BG_COLOR recolours without editing the bitmap.

Optional Feature:
- Macro CACTUS_S_OUTREG_EN.
- Defined: adds a second output register, equivalent to the BRAM output register, giving latency 2.
  - Both stages reset asynchronously to BG_COLOR.
  - The out-of-range check is applied in stage 1.
- Undefined: single register, latency 1, as described above.

Decomposition:
- Package cactus_pkg holds:
  - the sprite dimension constants (HEIGHT, LENGTH, DEPTH);
  - the DW pixel typedef;
  - the colour constants (FG_COLOR, BG_COLOR);
  - the 10-entry row-bitmap constant array.
- One natural sub-module: cactus_s_lut, purely combinational.
  - It maps addr to a pixel, including the range check.
  - cactus_s_ip wraps it with the reset-able output register(s).

Test Plan:
- Reset: hold rst_n=0 with toggling clk and addr=0 -> dout=12'hfff throughout. Assert rst_n low asynchronously mid-cycle -> dout=12'hfff before the next edge.
- Full sweep: after reset, drive addr 0..79 one per cycle -> dout one cycle later matches the bitmap. Concrete checks:
  - addr 3 -> 12'h535; addr 0 -> 12'hfff;
  - addr 17 (row 2, col 1) -> 12'h535;
  - addr 40 (row 5, col 0) -> 12'hfff; addr 41 -> 12'h535.
- Out of range: addr 80, 81, 16'h8000 and 16'hffff -> 12'hfff one cycle later.
- Back-to-back alternation: addr 3,0,3,0 on consecutive cycles -> dout 535,fff,535,fff delayed by exactly 1 cycle, with no glitches at the edges.
- CACTUS_S_OUTREG_EN build: repeat the sweep -> identical values delayed by 2 cycles. After reset release, the first two outputs are 12'hfff.
